// File: rtl/pkg_cpu.sv
// Shared CPU definitions: word width, flag bit positions, and divider types.
package pkg_cpu;

  localparam int CpuWordWidth = 32;

  // Flag vector layout {N,V,Z,C}
  localparam int FlagN = 3;
  localparam int FlagV = 2;
  localparam int FlagZ = 1;
  localparam int FlagC = 0;

  localparam logic [CpuWordWidth-1:0] DivMinNeg = {1'b1, {(CpuWordWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    DivIdle  = 2'd0,
    DivCalc  = 2'd1,
    DivFixup = 2'd2,
    DivDone  = 2'd3
  } DivState;

  typedef struct packed {
    logic                    is_signed;
    logic [CpuWordWidth-1:0] a_in;
    logic [CpuWordWidth-1:0] b_in;
    logic [3:0]              flags_in;
  } StrcInDivider;

  typedef struct packed {
    logic [CpuWordWidth-1:0] quot;
    logic [CpuWordWidth-1:0] rem;
    logic [3:0]              flags_out;
  } StrcOutDivider;

endpackage

// File: rtl/cpu_divider_step.sv
// One restoring-division step: shift in the next dividend bit and
// subtract the divisor if it fits.
module cpu_divider_step #(
  parameter int WORD_WIDTH = 32
) (
  input  logic [WORD_WIDTH-1:0] prem,
  input  logic                  dividend_msb,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic [WORD_WIDTH-1:0] next_prem,
  output logic                  q_bit
);

  logic [WORD_WIDTH:0] shifted_s;
  logic [WORD_WIDTH:0] trial_s;

  // The shifted remainder needs W+1 bits; a borrow shows up in the top bit.
  always_comb begin
    shifted_s = {prem, dividend_msb};
    trial_s   = shifted_s - {1'b0, divisor};
    q_bit     = ~trial_s[WORD_WIDTH];
    if (q_bit) begin
      next_prem = trial_s[WORD_WIDTH-1:0];
    end else begin
      next_prem = shifted_s[WORD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cpu_divider.sv
// Iterative restoring divider, one quotient bit per clock, with signed
// sign fixup and a two-cycle path for divide-by-zero and signed overflow.
module cpu_divider
  import pkg_cpu::*;
#(
  parameter int WORD_WIDTH = CpuWordWidth,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [WORD_WIDTH-1:0] a_in,
  input  logic [WORD_WIDTH-1:0] b_in,
  input  logic [3:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] quot,
  output logic [WORD_WIDTH-1:0] rem,
  output logic [3:0]            flags_out
);

  localparam logic [WORD_WIDTH-1:0] MinNeg  = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [WORD_WIDTH-1:0] AllOnes = {WORD_WIDTH{1'b1}};
  localparam logic [WORD_WIDTH-1:0] Zero    = {WORD_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CntInit = CNT_WIDTH'(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);

  DivState               state_q, state_d;
  logic [WORD_WIDTH-1:0] dvd_q, dvd_d;
  logic [WORD_WIDTH-1:0] dvs_q, dvs_d;
  logic [WORD_WIDTH-1:0] prem_q, prem_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic                  special_q, special_d;
  logic [3:0]            flags_lat_q, flags_lat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WORD_WIDTH-1:0] quot_q, quot_d;
  logic [WORD_WIDTH-1:0] rem_q, rem_d;
  logic [3:0]            flags_q, flags_d;

  logic                  a_neg_s, b_neg_s, is_special_s;
  logic [WORD_WIDTH-1:0] a_abs_s, b_abs_s;
  logic [WORD_WIDTH-1:0] step_prem_s;
  logic                  step_qbit_s;

  cpu_divider_step #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_step (
    .prem         (prem_q),
    .dividend_msb (dvd_q[WORD_WIDTH-1]),
    .divisor      (dvs_q),
    .next_prem    (step_prem_s),
    .q_bit        (step_qbit_s)
  );

  // Operand magnitudes and special-case detection at issue time.
  always_comb begin
    a_neg_s      = is_signed & a_in[WORD_WIDTH-1];
    b_neg_s      = is_signed & b_in[WORD_WIDTH-1];
    a_abs_s      = a_neg_s ? (Zero - a_in) : a_in;
    b_abs_s      = b_neg_s ? (Zero - b_in) : b_in;
    is_special_s = (b_in == Zero) | (is_signed & (a_in == MinNeg) & (b_in == AllOnes));
  end

  // Next-state and datapath; on the special path dvd/prem carry the final quot/rem.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    special_d   = special_q;
    flags_lat_d = flags_lat_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    flags_d     = flags_q;
    case (state_q)
      DivIdle: begin
        if (start) begin
          flags_lat_d = flags_in;
          special_d   = is_special_s;
          if (is_special_s) begin
            state_d = DivFixup;
            dvd_d   = (b_in == Zero) ? AllOnes : MinNeg;
            prem_d  = (b_in == Zero) ? a_in : Zero;
          end else begin
            state_d = DivCalc;
            dvd_d   = a_abs_s;
            dvs_d   = b_abs_s;
            prem_d  = Zero;
            cnt_d   = CntInit;
            qneg_d  = a_neg_s ^ b_neg_s;
            rneg_d  = a_neg_s;
          end
        end else begin
          state_d = DivIdle;
        end
      end
      DivCalc: begin
        prem_d = step_prem_s;
        dvd_d  = {dvd_q[WORD_WIDTH-2:0], step_qbit_s};
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = DivFixup;
        end else begin
          state_d = DivCalc;
        end
      end
      DivFixup: begin
        if (special_q) begin
          quot_d = dvd_q;
          rem_d  = prem_q;
        end else begin
          quot_d = qneg_q ? (Zero - dvd_q) : dvd_q;
          rem_d  = rneg_q ? (Zero - prem_q) : prem_q;
        end
        flags_d        = flags_lat_q;
        flags_d[FlagN] = quot_d[WORD_WIDTH-1];
        flags_d[FlagV] = special_q;
        flags_d[FlagZ] = (quot_d == Zero);
        state_d        = DivDone;
      end
      DivDone: begin
        state_d = DivIdle;
      end
      default: begin
        state_d = DivIdle;
      end
    endcase
    busy_d = (state_d != DivIdle);
    done_d = (state_d == DivDone);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DivIdle;
      dvd_q       <= Zero;
      dvs_q       <= Zero;
      prem_q      <= Zero;
      cnt_q       <= {CNT_WIDTH{1'b0}};
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      special_q   <= 1'b0;
      flags_lat_q <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quot_q      <= Zero;
      rem_q       <= Zero;
      flags_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      special_q   <= special_d;
      flags_lat_q <= flags_lat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      flags_q     <= flags_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_cpu_divider.sv
// Self-checking bench for cpu_divider: directed cases, busy/reset handling,
// and randomized operations against an arithmetic reference model.
module tb_cpu_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   flags_in = 4'b0000;
  logic         busy, done;
  logic [W-1:0] quot, rem;
  logic [3:0]   flags_out;

  int tests_run = 0;
  int tests_failed = 0;

  cpu_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a_in      (a_in),
    .b_in      (b_in),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .quot      (quot),
    .rem       (rem),
    .flags_out (flags_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division; flags are {N,V,Z,C}
  function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] fi, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic [3:0] f, output int lat);
    longint sa, sb, lq, lr;
    logic v;
    if (b == 0) begin
      q = {W{1'b1}}; r = a; v = 1'b1; lat = 2;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0; v = 1'b1; lat = 2;
    end else if (sg) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      lq = sa / sb; lr = sa % sb;
      q = lq[W-1:0]; r = lr[W-1:0]; v = 1'b0; lat = W + 2;
    end else begin
      q = a / b; r = a % b; v = 1'b0; lat = W + 2;
    end
    f = {q[W-1], v, (q == 0), fi[0]};
  endfunction

  // Issue one divide and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] fi, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic [3:0] f, output int lat);
    int edges;
    lat = -1;
    @(negedge clk);
    is_signed = sg; a_in = a; b_in = b; flags_in = fi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    while (edges < 100) begin
      @(negedge clk);
      if (done) begin
        lat = edges + 1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    q = quot; r = rem; f = flags_out;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, quot, rem, flags_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: got busy=%b done=%b quot=%h rem=%h flags=%b, expected all zero",
               busy, done, quot, rem, flags_out);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, quot, rem, flags_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: got busy=%b done=%b quot=%h rem=%h flags=%b, expected all zero",
               busy, done, quot, rem, flags_out);
    end
  endtask

  typedef struct packed {
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   fi;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [3:0]   ef;
    int           lat;
  } dir_case_t;

  task automatic test_directed();
    dir_case_t cs [9];
    logic [W-1:0] q, r;
    logic [3:0] f;
    int lat;
    cs[0] = '{1'b0, 32'd100,        32'd7,          4'b0001, 32'd14,         32'd2,          4'b0001, 34};
    cs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          4'b0000, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  4'b1000, 34};
    cs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  4'b0000, 32'hFFFF_FFFD,  32'd1,          4'b1000, 34};
    cs[3] = '{1'b0, 32'd5,          32'd0,          4'b0000, 32'hFFFF_FFFF,  32'd5,          4'b1100, 2};
    cs[4] = '{1'b1, 32'd5,          32'd0,          4'b0001, 32'hFFFF_FFFF,  32'd5,          4'b1101, 2};
    cs[5] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b0000, 32'd1,          32'd0,          4'b0000, 34};
    cs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  4'b0000, 32'h8000_0000,  32'd0,          4'b1100, 2};
    cs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  4'b0000, 32'd0,          32'h8000_0000,  4'b0010, 34};
    cs[8] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          4'b0000, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  4'b1100, 2};
    for (int i = 0; i < 9; i++) begin
      do_div(cs[i].sg, cs[i].a, cs[i].b, cs[i].fi, q, r, f, lat);
      tests_run += 4;
      if (q !== cs[i].eq) begin
        tests_failed++;
        $display("FAIL directed_quot[%0d]: got %h expected %h", i, q, cs[i].eq);
      end
      if (r !== cs[i].er) begin
        tests_failed++;
        $display("FAIL directed_rem[%0d]: got %h expected %h", i, r, cs[i].er);
      end
      if (f !== cs[i].ef) begin
        tests_failed++;
        $display("FAIL directed_flags[%0d]: got %b expected %b", i, f, cs[i].ef);
      end
      if (lat != cs[i].lat) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, cs[i].lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    logic [W-1:0] q = '0, r = '0;
    @(negedge clk);
    is_signed = 1'b0; a_in = 32'd100; b_in = 32'd7; flags_in = 4'b0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a_in = 32'd10; b_in = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_during_calc: got %b expected 1", busy);
    end
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        q = quot; r = rem;
      end
    end
    tests_run += 2;
    if (ndone != 1) begin
      tests_failed++;
      $display("FAIL busy_ignore_count: got %0d done pulses expected 1", ndone);
    end
    if ({q, r} !== {32'd14, 32'd2}) begin
      tests_failed++;
      $display("FAIL busy_ignore_result: got quot=%h rem=%h expected quot=%h rem=%h",
               q, r, 32'd14, 32'd2);
    end
  endtask

  task automatic test_start_held();
    int edges, lat;
    logic seen = 1'b0;
    @(negedge clk);
    is_signed = 1'b0; a_in = 32'd100; b_in = 32'd7; flags_in = 4'b0000; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen || quot !== 32'd14) begin
      tests_failed++;
      $display("FAIL held_first: got done_seen=%b quot=%h expected 1 and %h", seen, quot, 32'd14);
    end
    a_in = 32'd9; b_in = 32'd3;
    @(negedge clk);
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL held_idle_gap: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_reaccept: got busy=%b expected 1", busy);
    end
    lat = -1;
    edges = 1;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        lat = edges;
        break;
      end
    end
    tests_run += 2;
    if (lat != 34) begin
      tests_failed++;
      $display("FAIL held_latency: got %0d expected %0d", lat, 34);
    end
    if ({quot, rem} !== {32'd3, 32'd0}) begin
      tests_failed++;
      $display("FAIL held_second: got quot=%h rem=%h expected %h %h", quot, rem, 32'd3, 32'd0);
    end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    logic [W-1:0] q, r;
    logic [3:0] f;
    int lat;
    @(negedge clk);
    is_signed = 1'b0; a_in = 32'd100; b_in = 32'd7; flags_in = 4'b0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, quot, rem, flags_out} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%b done=%b quot=%h rem=%h flags=%b expected all zero",
               busy, done, quot, rem, flags_out);
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests_run++;
    if (ndone != 0) begin
      tests_failed++;
      $display("FAIL async_reset_no_done: got %0d done pulses expected 0", ndone);
    end
    do_div(1'b0, 32'd9, 32'd3, 4'b0000, q, r, f, lat);
    tests_run++;
    if ({q, r, lat} !== {32'd3, 32'd0, 34}) begin
      tests_failed++;
      $display("FAIL after_reset: got quot=%h rem=%h lat=%0d expected %h %h 34", q, r, lat, 32'd3, 32'd0);
    end
  endtask

  task automatic test_random();
    logic sg;
    logic [W-1:0] a, b, q, r, eq, er;
    logic [3:0] fi, f, ef;
    int lat, elat, mode;
    for (int i = 0; i < 60; i++) begin
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      fi = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 9);
      case (mode)
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: a = 32'h8000_0000;
        3, 4, 5: b = 32'($urandom_range(1, 20));
        6: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      ref_div(sg, a, b, fi, eq, er, ef, elat);
      do_div(sg, a, b, fi, q, r, f, lat);
      tests_run++;
      if (q !== eq || r !== er || f !== ef || lat != elat) begin
        tests_failed++;
        $display("FAIL random[%0d] sg=%b a=%h b=%h: got q=%h r=%h f=%b lat=%0d expected q=%h r=%h f=%b lat=%0d",
                 i, sg, a, b, q, r, f, lat, eq, er, ef, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_start_held();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
